// File: rtl/if_id_stage_skid.sv
// IF/ID stage with valid/ready on both sides, a 2-entry skid buffer,
// synchronous flush and a registered PC+4 sideband.
//
// Ports:
//   clk, rst (sync, active-low)  clock and reset
//   flush                        drop every held beat
//   in_valid/in_ready            fetch-side handshake
//   in_pc, in_instr              fetched beat
//   out_valid/out_ready          decode-side handshake
//   out_pc, out_pc_plus4         held beat PC and PC+4
//   out_instr                    held instruction, NOP when empty
module if_id_stage_skid #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [ILEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [ILEN-1:0] out_instr
);

  logic            main_valid;
  logic [XLEN-1:0] main_pc;
  logic [XLEN-1:0] main_pc4;
  logic [ILEN-1:0] main_instr;

  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_pc4;
  logic [ILEN-1:0] skid_instr;

  logic            in_fire;
  logic            out_fire;
  logic            take;
  logic            mv_skid;
  logic            ld_in;
  logic            drain;
  logic            park;
  logic [XLEN-1:0] in_pc4;

  assign in_ready  = !skid_valid;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready;
  assign in_pc4    = in_pc + XLEN'(4);

  // main is free to take a new beat when empty or being consumed
  assign take    = out_fire | !main_valid;
  assign mv_skid = take & skid_valid;
  assign ld_in   = take & !skid_valid & in_fire;
  assign drain   = take & !skid_valid & !in_fire;
  assign park    = !take & in_fire;

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_valid <= 1'b0;
      main_pc    <= '0;
      main_pc4   <= '0;
      main_instr <= NOP_INSTR;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_pc4   <= '0;
      skid_instr <= NOP_INSTR;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      unique case (1'b1)
        mv_skid: begin
          main_valid <= 1'b1;
          main_pc    <= skid_pc;
          main_pc4   <= skid_pc4;
          main_instr <= skid_instr;
          skid_valid <= 1'b0;
        end
        ld_in: begin
          main_valid <= 1'b1;
          main_pc    <= in_pc;
          main_pc4   <= in_pc4;
          main_instr <= in_instr;
        end
        drain: begin
          main_valid <= 1'b0;
        end
        park: begin
          skid_valid <= 1'b1;
          skid_pc    <= in_pc;
          skid_pc4   <= in_pc4;
          skid_instr <= in_instr;
        end
        default: ;
      endcase
    end
  end

  assign out_valid    = main_valid;
  assign out_pc       = main_pc;
  assign out_pc_plus4 = main_pc4;
  assign out_instr    = main_valid ? main_instr : NOP_INSTR;

endmodule

// File: doc/if_id_stage_skid.md
# if_id_stage_skid

Parametrised IF/ID pipeline stage for the RISC-V core with a valid/ready handshake on both sides, a two-entry skid buffer for full-throughput back-pressure, synchronous flush, and a registered PC+4 sideband. It sits between the fetch unit and the decoder. It replaces the plain always-load IF/ID register, which has no stall, flush or valid qualification.

## Interface
- `XLEN`, 32: PC width in bits.
- `ILEN`, 32: instruction width in bits.
- `NOP_INSTR`, 32'h0000_0013: bubble encoding (`addi x0,x0,0`) driven on `out_instr` when no valid beat is held.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-low (0 = reset).
- `flush`  input  1  kill all held beats (branch mispredict or trap); synchronous.
- `in_valid`  input  1  fetch presents a beat.
- `in_ready`  output  1  stage can accept a beat.
- `in_pc`  input  XLEN  PC of the fetched instruction.
- `in_instr`  input  ILEN  fetched instruction.
- `out_valid`  output  1  decode-side beat valid.
- `out_ready`  input  1  decoder accepts the beat.
- `out_pc`  output  XLEN  PC of the held beat.
- `out_pc_plus4`  output  XLEN  `out_pc + 4`, registered.
- `out_instr`  output  ILEN  instruction of the held beat, or `NOP_INSTR` when `out_valid` = 0.

## Operation
- Storage: one main register (`out_*`) and one skid register (`skid_pc`, `skid_instr`, `skid_valid`).
- Handshakes:
  - `in_fire = in_valid & in_ready`.
  - `out_fire = out_valid & out_ready`.
  - `in_ready = !skid_valid`. It depends only on registered state, with no combinational path from `out_ready`.
- States, derived from {`out_valid`, `skid_valid`}:
  - EMPTY (0,0):
    - `in_fire` loads main -> ONE.
    - Otherwise stay in EMPTY.
  - ONE (1,0):
    - `in_fire & out_fire` reloads main -> ONE.
    - `in_fire & !out_ready` writes skid -> FULL.
    - `out_fire` alone -> EMPTY.
    - Neither -> hold.
  - FULL (1,1):
    - `in_ready` = 0.
    - `out_fire` moves skid to main and clears skid -> ONE.
    - Otherwise hold.
  - (0,1) is illegal and unreachable.
- Ordering: beats leave in arrival order. No beat is duplicated or lost except by flush.
- PC+4: `out_pc_plus4` is computed from the incoming PC when main is loaded, modulo 2^XLEN. `32'hFFFF_FFFC` yields `32'h0000_0000`.
- Skid contents: skid stores PC+4 alongside PC, so a skid-to-main move requires no adder.
- Bubble: whenever main is not valid, `out_instr = NOP_INSTR`. `out_pc` and `out_pc_plus4` hold their last values (don't-care to the consumer).
- Flush:
  - Clears `out_valid` and `skid_valid`, and forces `out_instr = NOP_INSTR`.
  - Any beat completing `in_fire` in the same cycle is discarded.
  - Flush has priority over every load or move.
- Reset: `rst` = 0 has priority over flush and the handshakes.

## Timing
- Reset values, after the first rising edge with `rst` = 0:
  - `out_valid` = 0
  - `out_pc` = 0
  - `out_pc_plus4` = 0
  - `out_instr` = `NOP_INSTR`
  - skid empty, so `in_ready` = 1 from that point on.
- Latency: a beat accepted at edge N is visible on `out_*` with `out_valid` = 1 after edge N (one cycle).
- Throughput: one beat per cycle while `out_ready` = 1.
- Back-pressure: when `out_ready` drops for the first time, `in_ready` drops one cycle later. The in-flight beat is captured in skid.
- Skid drain: when `out_ready` rises in FULL, `in_ready` returns to 1 the cycle after `out_fire`.
- Mid-operation reset (`rst` low while FULL): both entries are cleared at that edge and no beat is emitted.
- Flush with `out_ready` = 1 in the same cycle: the current beat counts as consumed by the decoder, the skid beat is dropped, and the next state is EMPTY.
- Simultaneous `in_fire`, `out_fire` and `flush`: the result is EMPTY.
- `out_valid` never drops without an `out_fire`, flush or reset. `out_*` data is stable while `out_valid & !out_ready`.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles with `in_valid` = 1 -> `out_valid` = 0, `out_instr` = 32'h0000_0013, `out_pc` = 0, `in_ready` = 1 after release.
- Streaming: with `out_ready` = 1, send PC 0/4/8 and instructions 32'h1111_1111/2222_2222/3333_3333 back-to-back -> same sequence out, one cycle later, with `out_pc_plus4` = 4/8/C.
- Back-pressure:
  - Stimulus: drop `out_ready` while streaming PC 0,4,8.
  - Response: `out` holds PC 0; PC 4 goes to skid; `in_ready` = 0; PC 8 is held by fetch.
  - Then raise `out_ready` -> 0, 4, 8 delivered in order with no gap after the drain.
- Flush in FULL with `in_valid` = 1 (PC C) -> next cycle EMPTY, `out_instr` = NOP, and PC C never appears on the output.
- Wrap: `in_pc` = 32'hFFFF_FFFC -> `out_pc_plus4` = 32'h0000_0000.
- Random: random `in_valid`/`out_ready`/`flush` for 10k cycles against a reference queue model -> order preserved, no loss except flushed beats, and `out_*` stable under stall.
